spi_rxc: RTL and testbench

SPI receive controller: the receive-side counterpart of `spi_txc`. It samples the serial line on `sclk_rx` and assembles 8/16/32-bit frames, MSB- or LSB-first. It counts data frames up to `spi_rnum_max` and, when CRC is enabled, checks the trailing CRC frame against a CRC computed on the fly. It sits between the SPI pad logic and the receive FIFO/register block.

---
 rtl/spi_rxc.sv | 179 +++++++++++++++++
 tb/tb_spi_rxc.sv | 295 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_rxc.sv
`default_nettype none
// ============================================================================
//  Module   : spi_rxc
//  Brief    : SPI receive controller. Samples shift_in on sclk_rx, assembles
//             8/16/32-bit frames MSB- or LSB-first, counts data frames per
//             block and checks an optional trailing CRC frame.
//  Revision : 1.0 - initial release
// ============================================================================
module spi_rxc #(
    parameter int TNUM_W = 13
) (
    input  logic              sclk_rx,
    input  logic              spi_rx_rst,
    input  logic              shift_in,
    input  logic              rx_en,
    input  logic [1:0]        df,
    input  logic              lsbf,
    input  logic              crc_en,
    input  logic              rxonly,
    input  logic [TNUM_W-1:0] spi_rnum_max,
    input  logic [31:0]       crc_poly,
    output logic [31:0]       rx_data,
    output logic              rx_valid,
    output logic              rx_crc_frame,
    output logic              rx_num_max_en,
    output logic [31:0]       rx_crc_data_out,
    output logic              crc_err
);

    typedef enum logic [0:0] {
        ST_DATA = 1'b0,
        ST_CRC  = 1'b1
    } state_t;

    state_t              state_q, state_d;
    logic [5:0]          bit_cnt_q, bit_cnt_d;
    logic [31:0]         sh_q, sh_d;
    logic [TNUM_W-1:0]   frame_cnt_q, frame_cnt_d;
    logic [31:0]         crc_q, crc_d;
    logic [31:0]         rx_data_q, rx_data_d;
    logic                rx_valid_q, rx_valid_d;
    logic                rx_crc_frame_q, rx_crc_frame_d;
    logic                crc_err_q, crc_err_d;

    logic [5:0]          w_last_bit;
    logic [31:0]         w_mask;
    logic [31:0]         w_sh_base;
    logic [31:0]         w_sh_next;
    logic [31:0]         w_word;
    logic                w_frame_done;
    logic                w_fb;
    logic [31:0]         w_crc_step;
    logic [TNUM_W-1:0]   w_max_eff;
    logic                w_last_frame;
    logic                w_unused_rxonly;

    // rxonly is a status bit for software and plays no part in reception
    assign w_unused_rxonly = rxonly;

    // Frame width decode: index of the last bit and the word mask
    always_comb begin
        w_last_bit = 6'd7;
        w_mask     = 32'h0000_00FF;
        case (df)
            2'b01:   begin w_last_bit = 6'd15; w_mask = 32'h0000_FFFF; end
            2'b10:   begin w_last_bit = 6'd31; w_mask = 32'hFFFF_FFFF; end
            default: begin w_last_bit = 6'd7;  w_mask = 32'h0000_00FF; end
        endcase
    end

    // Shift-register update for the bit sampled this edge; LSB-first frames
    // start from a cleared register so stale bits never leak into the word
    always_comb begin
        w_sh_base = (bit_cnt_q == 6'd0) ? 32'd0 : sh_q;
        w_sh_next = {sh_q[30:0], shift_in};
        if (lsbf) begin
            w_sh_next                 = w_sh_base;
            w_sh_next[bit_cnt_q[4:0]] = shift_in;
        end
    end

    assign w_word       = w_sh_next & w_mask;
    assign w_frame_done = rx_en && (bit_cnt_q == w_last_bit);

    // Serial CRC: feedback from the top bit of the active width
    assign w_fb       = crc_q[w_last_bit[4:0]] ^ shift_in;
    assign w_crc_step = ({crc_q[30:0], 1'b0} ^ (w_fb ? crc_poly : 32'd0)) & w_mask;

    // A block size of 0 behaves as 1
    assign w_max_eff    = (spi_rnum_max == '0) ? TNUM_W'(1) : spi_rnum_max;
    assign w_last_frame = (frame_cnt_q == (w_max_eff - TNUM_W'(1)));

    // Next-state logic: bit/frame counting, assembly, CRC and DATA/CRC FSM
    always_comb begin
        state_d        = state_q;
        bit_cnt_d      = bit_cnt_q;
        sh_d           = sh_q;
        frame_cnt_d    = frame_cnt_q;
        crc_d          = crc_q;
        rx_data_d      = rx_data_q;
        rx_valid_d     = 1'b0;
        rx_crc_frame_d = 1'b0;
        crc_err_d      = crc_err_q;

        if (!rx_en) begin
            // Chip select inactive: any partial frame is dropped
            bit_cnt_d = 6'd0;
            sh_d      = 32'd0;
        end else begin
            sh_d      = w_sh_next;
            bit_cnt_d = w_frame_done ? 6'd0 : (bit_cnt_q + 6'd1);
            case (state_q)
                ST_DATA: begin
                    crc_d = w_crc_step;
                    if (w_frame_done) begin
                        rx_data_d  = w_word;
                        rx_valid_d = 1'b1;
                        if (w_last_frame) begin
                            frame_cnt_d = '0;
                            if (crc_en) begin
                                state_d = ST_CRC;
                            end else begin
                                crc_d = 32'd0;
                            end
                        end else begin
                            frame_cnt_d = frame_cnt_q + TNUM_W'(1);
                        end
                    end
                end
                ST_CRC: begin
                    // CRC register is frozen while the check frame arrives
                    if (w_frame_done) begin
                        rx_crc_frame_d = 1'b1;
                        if (w_word != crc_q) begin
                            crc_err_d = 1'b1;
                        end
                        crc_d   = 32'd0;
                        state_d = ST_DATA;
                    end
                end
                default: state_d = ST_DATA;
            endcase
        end
    end

    // State and datapath registers
    always_ff @(posedge sclk_rx or posedge spi_rx_rst) begin
        if (spi_rx_rst) begin
            state_q        <= ST_DATA;
            bit_cnt_q      <= 6'd0;
            sh_q           <= 32'd0;
            frame_cnt_q    <= '0;
            crc_q          <= 32'd0;
            rx_data_q      <= 32'd0;
            rx_valid_q     <= 1'b0;
            rx_crc_frame_q <= 1'b0;
            crc_err_q      <= 1'b0;
        end else begin
            state_q        <= state_d;
            bit_cnt_q      <= bit_cnt_d;
            sh_q           <= sh_d;
            frame_cnt_q    <= frame_cnt_d;
            crc_q          <= crc_d;
            rx_data_q      <= rx_data_d;
            rx_valid_q     <= rx_valid_d;
            rx_crc_frame_q <= rx_crc_frame_d;
            crc_err_q      <= crc_err_d;
        end
    end

    assign rx_data         = rx_data_q;
    assign rx_valid        = rx_valid_q;
    assign rx_crc_frame    = rx_crc_frame_q;
    assign rx_crc_data_out = crc_q;
    assign crc_err         = crc_err_q;
    assign rx_num_max_en   = (state_q == ST_DATA) && w_last_frame;

endmodule
`default_nettype wire

// File: tb/tb_spi_rxc.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
//  Module   : tb_spi_rxc
//  Brief    : Self-checking bench for spi_rxc (vector table, scoreboard
//             queues for data and CRC-frame pulses, corner-case sequences).
//  Revision : 1.0 - initial release
// ============================================================================
module tb_spi_rxc;

    localparam int TNUM_W = 13;

    logic              clk = 1'b0;
    logic              rst;
    logic              shift_in;
    logic              rx_en;
    logic [1:0]        df;
    logic              lsbf;
    logic              crc_en;
    logic              rxonly;
    logic [TNUM_W-1:0] rnum_max;
    logic [31:0]       poly;
    logic [31:0]       rx_data;
    logic              rx_valid;
    logic              rx_crc_frame;
    logic              rx_num_max_en;
    logic [31:0]       rx_crc_data_out;
    logic              crc_err;

    spi_rxc #(.TNUM_W(TNUM_W)) dut (
        .sclk_rx        (clk),
        .spi_rx_rst     (rst),
        .shift_in       (shift_in),
        .rx_en          (rx_en),
        .df             (df),
        .lsbf           (lsbf),
        .crc_en         (crc_en),
        .rxonly         (rxonly),
        .spi_rnum_max   (rnum_max),
        .crc_poly       (poly),
        .rx_data        (rx_data),
        .rx_valid       (rx_valid),
        .rx_crc_frame   (rx_crc_frame),
        .rx_num_max_en  (rx_num_max_en),
        .rx_crc_data_out(rx_crc_data_out),
        .crc_err        (crc_err)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    logic [31:0] data_q[$];
    logic        err_q[$];

    typedef struct {
        logic [1:0]  df;
        logic        lsbf;
        logic [31:0] data;
        logic [31:0] exp;
    } vec_t;

    vec_t vecs[7];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int width_of(input logic [1:0] d);
        if (d == 2'b01) return 16;
        if (d == 2'b10) return 32;
        return 8;
    endfunction

    function automatic logic [31:0] mask_of(input int w);
        if (w == 32) return 32'hFFFF_FFFF;
        return (32'h1 << w) - 32'h1;
    endfunction

    // Reference CRC over a frame sent MSB-first, starting from crc_in
    function automatic logic [31:0] crc_model(input logic [31:0] crc_in, input logic [31:0] value,
                                              input int w, input logic [31:0] p);
        logic [31:0] c;
        logic        fb;
        c = crc_in;
        for (int i = w - 1; i >= 0; i--) begin
            fb = c[w-1] ^ value[i];
            c  = ((c << 1) ^ (fb ? p : 32'd0)) & mask_of(w);
        end
        return c;
    endfunction

    // Scoreboard: every rx_valid / rx_crc_frame pulse must match a queued entry
    always @(posedge clk) begin
        #1;
        if (rx_valid) begin
            if (data_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_rx_valid: got rx_data 0x%08h expected no pulse", rx_data);
            end else begin
                check("sb_rx_data", rx_data, data_q.pop_front());
            end
        end
        if (rx_crc_frame) begin
            if (err_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_rx_crc_frame: got pulse expected none");
            end else begin
                check("sb_crc_err", {31'd0, crc_err}, {31'd0, err_q.pop_front()});
            end
        end
    end

    task automatic send_bits(input logic [31:0] value, input int w, input logic lsb, input int nbits);
        for (int i = 0; i < nbits; i++) begin
            @(negedge clk);
            rx_en    = 1'b1;
            shift_in = lsb ? value[i] : value[w-1-i];
        end
    endtask

    // Sends a full frame with the current df/lsbf; returns #1 after the completion edge
    task automatic send_frame(input logic [31:0] value, input bit is_data);
        int w;
        w = width_of(df);
        if (is_data) data_q.push_back(value & mask_of(w));
        send_bits(value, w, lsbf, w);
        @(posedge clk);
        #1;
    endtask

    task automatic idle_cycle();
        @(negedge clk);
        rx_en = 1'b0;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst   = 1'b1;
        rx_en = 1'b0;
        @(negedge clk);
        rst   = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0] = '{df: 2'b00, lsbf: 1'b0, data: 32'h0000_0078, exp: 32'h0000_0078};
        vecs[1] = '{df: 2'b00, lsbf: 1'b1, data: 32'h0000_0078, exp: 32'h0000_0078};
        vecs[2] = '{df: 2'b01, lsbf: 1'b1, data: 32'h0000_CCDD, exp: 32'h0000_CCDD};
        vecs[3] = '{df: 2'b10, lsbf: 1'b1, data: 32'h55AA_55AA, exp: 32'h55AA_55AA};
        vecs[4] = '{df: 2'b01, lsbf: 1'b0, data: 32'h0000_1234, exp: 32'h0000_1234};
        vecs[5] = '{df: 2'b10, lsbf: 1'b0, data: 32'hDEAD_BEEF, exp: 32'hDEAD_BEEF};
        vecs[6] = '{df: 2'b11, lsbf: 1'b0, data: 32'h0000_003C, exp: 32'h0000_003C};

        rst      = 1'b1;
        shift_in = 1'b0;
        rx_en    = 1'b0;
        df       = 2'b00;
        lsbf     = 1'b0;
        crc_en   = 1'b0;
        rxonly   = 1'b1;
        rnum_max = TNUM_W'(2);
        poly     = 32'h0000_0007;
        #12;
        rst = 1'b0;

        // Reset state
        @(posedge clk);
        #1;
        check("reset_rx_data", rx_data, 32'd0);
        check("reset_rx_valid", {31'd0, rx_valid}, 32'd0);
        check("reset_crc_out", rx_crc_data_out, 32'd0);
        check("reset_crc_err", {31'd0, crc_err}, 32'd0);
        check("reset_num_max_en", {31'd0, rx_num_max_en}, 32'd0);

        // Frame assembly across widths and bit orders
        rnum_max = TNUM_W'(1);
        for (int i = 0; i < 7; i++) begin
            @(negedge clk);
            rx_en = 1'b0;
            df    = vecs[i].df;
            lsbf  = vecs[i].lsbf;
            send_frame(vecs[i].data, 1'b1);
            check($sformatf("vec%0d_rx_data", i), rx_data, vecs[i].exp);
            check($sformatf("vec%0d_rx_valid", i), {31'd0, rx_valid}, 32'd1);
            check($sformatf("vec%0d_crc_cleared", i), rx_crc_data_out, 32'd0);
            check($sformatf("vec%0d_num_max_en", i), {31'd0, rx_num_max_en}, 32'd1);
            idle_cycle();
            check($sformatf("vec%0d_valid_one_cycle", i), {31'd0, rx_valid}, 32'd0);
        end

        // Block counting without CRC
        do_reset();
        df       = 2'b00;
        lsbf     = 1'b0;
        crc_en   = 1'b0;
        rnum_max = TNUM_W'(2);
        poly     = 32'h0000_0007;
        @(posedge clk);
        #1;
        check("blk_num_max_en_f1", {31'd0, rx_num_max_en}, 32'd0);
        send_frame(32'hAA, 1'b1);
        check("blk_num_max_en_f2", {31'd0, rx_num_max_en}, 32'd1);
        check("blk_crc_after_f1", rx_crc_data_out, crc_model(32'd0, 32'hAA, 8, 32'h07));
        send_frame(32'h55, 1'b1);
        check("blk_rx_data_f2", rx_data, 32'h55);
        check("blk_num_max_en_wrap", {31'd0, rx_num_max_en}, 32'd0);
        check("blk_crc_cleared", rx_crc_data_out, 32'd0);
        idle_cycle();

        // Abort mid-frame, then a complete frame
        do_reset();
        rnum_max = TNUM_W'(1);
        send_bits(32'hFF, 8, 1'b0, 5);
        idle_cycle();
        check("abort_no_pulse", {31'd0, rx_valid}, 32'd0);
        idle_cycle();
        send_frame(32'hA5, 1'b1);
        check("abort_rx_data", rx_data, 32'hA5);
        idle_cycle();

        // CRC pass / fail / sticky
        do_reset();
        crc_en   = 1'b1;
        df       = 2'b00;
        lsbf     = 1'b0;
        rnum_max = TNUM_W'(1);
        poly     = 32'h0000_0007;
        @(posedge clk);
        #1;
        check("crc_num_max_en_data", {31'd0, rx_num_max_en}, 32'd1);
        send_frame(32'h12, 1'b1);
        check("crc_value_0x12", rx_crc_data_out, 32'h7E);
        check("crc_num_max_en_in_crc", {31'd0, rx_num_max_en}, 32'd0);
        err_q.push_back(1'b0);
        send_frame(32'h7E, 1'b0);
        check("crc_pass_err", {31'd0, crc_err}, 32'd0);
        check("crc_pass_pulse", {31'd0, rx_crc_frame}, 32'd1);
        check("crc_reg_cleared", rx_crc_data_out, 32'd0);
        check("crc_rx_data_kept", rx_data, 32'h12);
        send_frame(32'h12, 1'b1);
        err_q.push_back(1'b1);
        send_frame(32'h7F, 1'b0);
        check("crc_fail_err", {31'd0, crc_err}, 32'd1);
        send_frame(32'h12, 1'b1);
        err_q.push_back(1'b1);
        send_frame(32'h7E, 1'b0);
        check("crc_err_sticky", {31'd0, crc_err}, 32'd1);
        idle_cycle();

        // Asynchronous reset between edges in the middle of a frame
        crc_en   = 1'b0;
        rnum_max = TNUM_W'(2);
        send_bits(32'hFF, 8, 1'b0, 3);
        @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        check("amid_rx_data", rx_data, 32'd0);
        check("amid_rx_valid", {31'd0, rx_valid}, 32'd0);
        check("amid_crc_frame", {31'd0, rx_crc_frame}, 32'd0);
        check("amid_crc_out", rx_crc_data_out, 32'd0);
        check("amid_crc_err", {31'd0, crc_err}, 32'd0);
        check("amid_num_max_en", {31'd0, rx_num_max_en}, 32'd0);
        #1;
        rst = 1'b0;
        send_frame(32'h3C, 1'b1);
        check("post_rst_rx_data", rx_data, 32'h3C);
        check("post_rst_num_max_en", {31'd0, rx_num_max_en}, 32'd1);
        idle_cycle();
        idle_cycle();

        check("sb_data_drained", data_q.size(), 32'd0);
        check("sb_crc_drained", err_q.size(), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
